// File: rtl/ifetch_miss_sequencer.sv
// Instruction-side L1 miss tracker: one entry per thread, round-robin L2 fill issue, wake-up on fill completion.
// Build option IFETCH_MISS_MERGE_EN: merge same-line misses and fold a miss that hits a completing fill into its wake set.
module ifetch_miss_sequencer #(
  parameter int unsigned NUM_THREADS     = 4,
  parameter int unsigned LINE_ADDR_WIDTH = 26,
  localparam int unsigned TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_en,
  input  logic [LINE_ADDR_WIDTH-1:0] miss_line_addr,
  input  logic [TW-1:0]              miss_thread_idx,
  output logic                       l2_req_valid,
  output logic [LINE_ADDR_WIDTH-1:0] l2_req_line_addr,
  output logic [TW-1:0]              l2_req_entry,
  input  logic                       l2_req_ready,
  input  logic                       l2_resp_valid,
  input  logic [TW-1:0]              l2_resp_entry,
  output logic [NUM_THREADS-1:0]     wake_en,
  output logic [NUM_THREADS-1:0]     miss_pending
);

  typedef enum logic [1:0] {
    ENTRY_IDLE,
    ENTRY_PENDING,
    ENTRY_ISSUED
  } entry_state_e;

  entry_state_e               state_q   [NUM_THREADS];
  entry_state_e               state_d   [NUM_THREADS];
  logic [LINE_ADDR_WIDTH-1:0] line_q    [NUM_THREADS];
  logic [LINE_ADDR_WIDTH-1:0] line_d    [NUM_THREADS];
  logic [NUM_THREADS-1:0]     waiters_q [NUM_THREADS];
  logic [NUM_THREADS-1:0]     waiters_d [NUM_THREADS];

  logic [TW-1:0]              ptr_q, ptr_d;
  logic                       req_valid_q, req_valid_d;
  logic [TW-1:0]              req_entry_q, req_entry_d;
  logic [LINE_ADDR_WIDTH-1:0] req_line_q, req_line_d;
  logic [NUM_THREADS-1:0]     wake_q, wake_d;

  logic                       accept;
  logic                       hit;
  logic [TW-1:0]              hit_idx;
  logic [TW-1:0]              cand;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        state_q[i]   <= ENTRY_IDLE;
        line_q[i]    <= '0;
        waiters_q[i] <= '0;
      end
      ptr_q       <= '0;
      req_valid_q <= 1'b0;
      req_entry_q <= '0;
      req_line_q  <= '0;
      wake_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      waiters_q   <= waiters_d;
      ptr_q       <= ptr_d;
      req_valid_q <= req_valid_d;
      req_entry_q <= req_entry_d;
      req_line_q  <= req_line_d;
      wake_q      <= wake_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    waiters_d   = waiters_q;
    ptr_d       = ptr_q;
    req_valid_d = req_valid_q;
    req_entry_d = req_entry_q;
    req_line_d  = req_line_q;
    wake_d      = '0;
    hit         = 1'b0;
    hit_idx     = '0;
    cand        = '0;
    accept      = req_valid_q && l2_req_ready;

`ifdef IFETCH_MISS_MERGE_EN
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      if (state_q[i] != ENTRY_IDLE && line_q[i] == miss_line_addr) begin
        hit     = 1'b1;
        hit_idx = TW'(i);
      end
    end
`endif

    if (accept) begin
      state_d[req_entry_q] = ENTRY_ISSUED;
      ptr_d = (req_entry_q == TW'(NUM_THREADS - 1)) ? '0 : req_entry_q + TW'(1);
    end

    if (l2_resp_valid) begin
      wake_d                   = waiters_q[l2_resp_entry];
      state_d[l2_resp_entry]   = ENTRY_IDLE;
      waiters_d[l2_resp_entry] = '0;
    end

    // A miss hitting the line being filled right now is woken with the fill instead of queued.
    if (miss_en) begin
      if (hit && l2_resp_valid && hit_idx == l2_resp_entry) begin
        wake_d[miss_thread_idx] = 1'b1;
      end else if (hit) begin
        waiters_d[hit_idx][miss_thread_idx] = 1'b1;
      end else begin
        state_d[miss_thread_idx]   = ENTRY_PENDING;
        line_d[miss_thread_idx]    = miss_line_addr;
        waiters_d[miss_thread_idx] = NUM_THREADS'(1) << miss_thread_idx;
      end
    end

    // Reload the request register from post-update state so back-to-back issue is possible.
    if (!req_valid_q || accept) begin
      req_valid_d = 1'b0;
      req_entry_d = '0;
      req_line_d  = '0;
      for (int unsigned k = 0; k < NUM_THREADS; k++) begin
        cand = TW'((32'(ptr_d) + k) % NUM_THREADS);
        if (!req_valid_d && state_d[cand] == ENTRY_PENDING) begin
          req_valid_d = 1'b1;
          req_entry_d = cand;
          req_line_d  = line_d[cand];
        end
      end
    end
  end

  always_comb begin
    l2_req_valid     = req_valid_q;
    l2_req_entry     = req_entry_q;
    l2_req_line_addr = req_line_q;
    wake_en          = wake_q;
    miss_pending     = '0;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      if (state_q[i] != ENTRY_IDLE) miss_pending = miss_pending | waiters_q[i];
    end
  end

  miss_thread_not_blocked: assert property (
    @(posedge clk) disable iff (!reset) miss_en |-> !miss_pending[miss_thread_idx]);

  resp_entry_issued: assert property (
    @(posedge clk) disable iff (!reset) l2_resp_valid |-> state_q[l2_resp_entry] == ENTRY_ISSUED);

endmodule

// File: tb/tb_ifetch_miss_sequencer.sv
// Self-checking bench for ifetch_miss_sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_ifetch_miss_sequencer;
  localparam int unsigned NT  = 4;
  localparam int unsigned LAW = 26;
  localparam int unsigned TW  = 2;
`ifdef IFETCH_MISS_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           miss_en = 1'b0;
  logic [LAW-1:0] miss_line_addr = '0;
  logic [TW-1:0]  miss_thread_idx = '0;
  logic           l2_req_valid;
  logic [LAW-1:0] l2_req_line_addr;
  logic [TW-1:0]  l2_req_entry;
  logic           l2_req_ready = 1'b0;
  logic           l2_resp_valid = 1'b0;
  logic [TW-1:0]  l2_resp_entry = '0;
  logic [NT-1:0]  wake_en;
  logic [NT-1:0]  miss_pending;

  always #5 clk = ~clk;

  ifetch_miss_sequencer #(.NUM_THREADS(NT), .LINE_ADDR_WIDTH(LAW)) dut (
    .clk(clk), .reset(reset),
    .miss_en(miss_en), .miss_line_addr(miss_line_addr), .miss_thread_idx(miss_thread_idx),
    .l2_req_valid(l2_req_valid), .l2_req_line_addr(l2_req_line_addr), .l2_req_entry(l2_req_entry),
    .l2_req_ready(l2_req_ready), .l2_resp_valid(l2_resp_valid), .l2_resp_entry(l2_resp_entry),
    .wake_en(wake_en), .miss_pending(miss_pending)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: per-entry lifecycle flags, line, waiter set; request slot and rotating pointer.
  bit             m_valid  [NT];
  bit             m_issued [NT];
  logic [LAW-1:0] m_line   [NT];
  logic [NT-1:0]  m_wait   [NT];
  int             m_ptr;
  bit             m_req_valid;
  int             m_req_entry;
  logic [NT-1:0]  m_wake;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [NT-1:0] model_pending();
    logic [NT-1:0] p = '0;
    for (int i = 0; i < NT; i++) if (m_valid[i]) p |= m_wait[i];
    return p;
  endfunction

  function automatic bit model_busy();
    bit b = m_req_valid;
    for (int i = 0; i < NT; i++) if (m_valid[i]) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_valid[i] = 1'b0; m_issued[i] = 1'b0; m_line[i] = '0; m_wait[i] = '0;
    end
    m_ptr = 0; m_req_valid = 1'b0; m_req_entry = 0; m_wake = '0;
  endtask

  task automatic model_step();
    logic [NT-1:0] nw;
    int hit, t, e, j;
    bit acc;
    nw  = '0;
    hit = -1;
    t   = int'(miss_thread_idx);
    e   = int'(l2_resp_entry);
    if (MERGE && miss_en)
      for (int i = 0; i < NT; i++) if (m_valid[i] && m_line[i] == miss_line_addr) hit = i;
    if (l2_resp_valid) nw = m_wait[e];
    acc = m_req_valid && l2_req_ready;
    if (acc) begin
      m_issued[m_req_entry] = 1'b1;
      m_ptr = (m_req_entry + 1) % NT;
    end
    if (l2_resp_valid) begin
      m_valid[e] = 1'b0; m_issued[e] = 1'b0; m_wait[e] = '0;
    end
    if (miss_en) begin
      if (hit >= 0 && l2_resp_valid && hit == e) nw[t] = 1'b1;
      else if (hit >= 0) m_wait[hit][t] = 1'b1;
      else begin
        m_valid[t] = 1'b1; m_issued[t] = 1'b0; m_line[t] = miss_line_addr;
        m_wait[t] = '0; m_wait[t][t] = 1'b1;
      end
    end
    m_wake = nw;
    if (!m_req_valid || acc) begin
      m_req_valid = 1'b0;
      for (int k = 0; k < NT; k++) begin
        j = (m_ptr + k) % NT;
        if (!m_req_valid && m_valid[j] && !m_issued[j]) begin
          m_req_valid = 1'b1;
          m_req_entry = j;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("req_valid", 32'(l2_req_valid), 32'(m_req_valid));
    if (m_req_valid) begin
      check_eq("req_entry", 32'(l2_req_entry), 32'(m_req_entry));
      check_eq("req_line", 32'(l2_req_line_addr), 32'(m_line[m_req_entry]));
    end
    check_eq("wake_en", 32'(wake_en), 32'(m_wake));
    check_eq("miss_pending", 32'(miss_pending), 32'(model_pending()));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    miss_en = 1'b0;
    l2_resp_valid = 1'b0;
  endtask

  task automatic set_miss(input int t, input logic [LAW-1:0] line);
    miss_en = 1'b1; miss_thread_idx = TW'(t); miss_line_addr = line;
  endtask

  task automatic set_resp(input int e);
    l2_resp_valid = 1'b1; l2_resp_entry = TW'(e);
  endtask

  task automatic drain();
    int issued_q[$];
    int n;
    n = 0;
    l2_req_ready = 1'b1;
    while (model_busy() && n < 200) begin
      issued_q.delete();
      for (int i = 0; i < NT; i++) if (m_issued[i]) issued_q.push_back(i);
      if (issued_q.size() > 0) set_resp(issued_q[$urandom_range(0, issued_q.size() - 1)]);
      cycle();
      n++;
    end
    l2_req_ready = 1'b0;
    cycle();
    check_eq("drain_pending", 32'(miss_pending), 32'h0);
    check_eq("drain_req_valid", 32'(l2_req_valid), 32'h0);
  endtask

  initial begin
    int n_acc;
    int ent_q[$];
    int issued_q[$];
    logic [NT-1:0] pm;
    logic [LAW-1:0] pool [4];
    int t;
    pool[0] = 26'h000040; pool[1] = 26'h000123; pool[2] = 26'h0ABCDE; pool[3] = 26'h00F00D;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check_eq("rst_req_valid", 32'(l2_req_valid), 32'h0);
    check_eq("rst_req_line", 32'(l2_req_line_addr), 32'h0);
    check_eq("rst_req_entry", 32'(l2_req_entry), 32'h0);
    check_eq("rst_wake", 32'(wake_en), 32'h0);
    check_eq("rst_pending", 32'(miss_pending), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single miss, issue, fill, wake
    set_miss(2, 26'h000123);
    cycle();
    check_eq("t1_req_valid", 32'(l2_req_valid), 32'h1);
    check_eq("t1_req_line", 32'(l2_req_line_addr), 32'h123);
    check_eq("t1_req_entry", 32'(l2_req_entry), 32'h2);
    check_eq("t1_pending", 32'(miss_pending), 32'h4);
    l2_req_ready = 1'b1;
    cycle();
    l2_req_ready = 1'b0;
    check_eq("t1_req_done", 32'(l2_req_valid), 32'h0);
    set_resp(2);
    cycle();
    check_eq("t1_wake", 32'(wake_en), 32'h4);
    check_eq("t1_pending_clr", 32'(miss_pending), 32'h0);
    cycle();
    check_eq("t1_wake_pulse", 32'(wake_en), 32'h0);

`ifdef IFETCH_MISS_MERGE_EN
    // Two threads, same line: one request, one combined wake
    set_miss(0, 26'h0ABCDE);
    cycle();
    cycle();
    set_miss(3, 26'h0ABCDE);
    cycle();
    check_eq("t2_pending", 32'(miss_pending), 32'h9);
    l2_req_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (l2_req_valid) n_acc++;
      cycle();
    end
    l2_req_ready = 1'b0;
    check_eq("t2_one_request", 32'(n_acc), 32'h1);
    set_resp(0);
    cycle();
    check_eq("t2_wake", 32'(wake_en), 32'h9);
    cycle();
    check_eq("t2_wake_pulse", 32'(wake_en), 32'h0);
`else
    // Two threads, same line, no merging: two requests, separate wakes
    set_miss(0, 26'h000040);
    cycle();
    set_miss(1, 26'h000040);
    cycle();
    l2_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (l2_req_valid) ent_q.push_back(int'(l2_req_entry));
      cycle();
    end
    l2_req_ready = 1'b0;
    check_eq("t6_num_requests", 32'(ent_q.size()), 32'h2);
    if (ent_q.size() == 2) begin
      check_eq("t6_first_entry", 32'(ent_q[0]), 32'h0);
      check_eq("t6_second_entry", 32'(ent_q[1]), 32'h1);
    end
    set_resp(0);
    cycle();
    check_eq("t6_wake0", 32'(wake_en), 32'h1);
    set_resp(1);
    cycle();
    check_eq("t6_wake1", 32'(wake_en), 32'h2);
    cycle();
`endif

    // Burst of four distinct misses, ready held low, then round-robin drain
    for (int k = 0; k < NT; k++) begin
      set_miss(k, 26'h001000 + LAW'(k));
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_valid", 32'(l2_req_valid), 32'h1);
      check_eq("t3_hold_entry", 32'(l2_req_entry), 32'h0);
      check_eq("t3_hold_line", 32'(l2_req_line_addr), 32'h1000);
      cycle();
    end
    l2_req_ready = 1'b1;
    for (int k = 0; k < NT; k++) begin
      check_eq("t3_order_valid", 32'(l2_req_valid), 32'h1);
      check_eq("t3_order_entry", 32'(l2_req_entry), 32'(k));
      cycle();
    end
    l2_req_ready = 1'b0;
    check_eq("t3_all_issued", 32'(l2_req_valid), 32'h0);
    for (int k = 0; k < NT; k++) begin
      set_resp(k);
      cycle();
      check_eq("t3_wake", 32'(wake_en), 32'(1 << k));
    end
    cycle();

    // Miss to a line whose fill completes in the same cycle
    set_miss(0, 26'h00F00D);
    cycle();
    l2_req_ready = 1'b1;
    cycle();
    l2_req_ready = 1'b0;
    set_resp(0);
    set_miss(1, 26'h00F00D);
    cycle();
`ifdef IFETCH_MISS_MERGE_EN
    check_eq("t4_wake", 32'(wake_en), 32'h3);
    check_eq("t4_no_request", 32'(l2_req_valid), 32'h0);
    check_eq("t4_pending", 32'(miss_pending), 32'h0);
`else
    check_eq("t4_wake", 32'(wake_en), 32'h1);
    check_eq("t4_queued", 32'(l2_req_valid), 32'h1);
    check_eq("t4_queued_entry", 32'(l2_req_entry), 32'h1);
`endif
    drain();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      l2_req_ready = ($urandom_range(0, 3) != 0);
      pm = model_pending();
      if ($urandom_range(0, 1) == 1) begin
        t = $urandom_range(0, NT - 1);
        if (!pm[t]) set_miss(t, ($urandom_range(0, 3) == 0) ? LAW'($urandom) : pool[$urandom_range(0, 3)]);
      end
      issued_q.delete();
      for (int i = 0; i < NT; i++) if (m_issued[i]) issued_q.push_back(i);
      if (issued_q.size() > 0 && $urandom_range(0, 2) == 0)
        set_resp(issued_q[$urandom_range(0, issued_q.size() - 1)]);
      cycle();
    end
    drain();

    // Asynchronous reset while an entry is issued and another request is presented
    set_miss(1, 26'h0000AA);
    cycle();
    l2_req_ready = 1'b1;
    set_miss(2, 26'h0000BB);
    cycle();
    l2_req_ready = 1'b0;
    check_eq("t5_pre_valid", 32'(l2_req_valid), 32'h1);
    check_eq("t5_pre_entry", 32'(l2_req_entry), 32'h2);
    #2 reset = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(l2_req_valid), 32'h0);
    check_eq("t5_rst_line", 32'(l2_req_line_addr), 32'h0);
    check_eq("t5_rst_entry", 32'(l2_req_entry), 32'h0);
    check_eq("t5_rst_wake", 32'(wake_en), 32'h0);
    check_eq("t5_rst_pending", 32'(miss_pending), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
